// File: rtl/ex_muldiv_if.sv
// Operand/result bundle between the ID/EX pipeline register and the M-extension unit.
// No latency of its own: wires only.
// The unit stalls the front of the pipe through o_busy; the pipe cannot push back on o_done.
`timescale 1ns/1ps
interface ex_muldiv_if #(
    parameter int XLEN = 32
);
    logic            i_flush;
    logic            i_start;
    logic [2:0]      i_funct3;
    logic [XLEN-1:0] i_rs1_data;
    logic [XLEN-1:0] i_rs2_data;
    logic [4:0]      i_rd_addr;
    logic            o_busy;
    logic            o_done;
    logic [XLEN-1:0] o_result;
    logic [4:0]      o_rd_addr;

    // Pipeline side: issues the M-op, watches the stall and the result.
    modport master (
        output i_flush, i_start, i_funct3, i_rs1_data, i_rs2_data, i_rd_addr,
        input  o_busy, o_done, o_result, o_rd_addr
    );

    // Unit side.
    modport slave (
        input  i_flush, i_start, i_funct3, i_rs1_data, i_rs2_data, i_rd_addr,
        output o_busy, o_done, o_result, o_rd_addr
    );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide: shift-add multiply, restoring divide on magnitudes.
// Latency XLEN+1 cycles to the o_done pulse; divide-by-zero and signed overflow finish in 1.
// Holds the front of the pipe with o_busy while working; o_done is a one-cycle pulse, no stall.
`timescale 1ns/1ps
module ex_muldiv #(
    parameter int XLEN = 32
) (
    input  logic       i_clk,
    input  logic       i_reset,
    ex_muldiv_if.slave bus
);
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [4:0]        rd_q, rd_d;
    logic              neg_q, neg_d;      // negate the final result
    logic [XLEN-1:0]   a_q, a_d;          // multiplicand
    logic [XLEN-1:0]   b_q, b_d;          // divisor magnitude
    logic [2*XLEN-1:0] prod_q, prod_d;    // MUL: {acc, multiplier}; DIV: {remainder, dividend/quotient}
    logic [XLEN-1:0]   res_q, res_d;
    logic [4:0]        rd_out_q, rd_out_d;

    // Operand decode at issue time.
    logic            a_sgn, b_sgn, a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0] mag_a, mag_b, fast_res;

    assign a_sgn    = bus.i_funct3[2] ? ~bus.i_funct3[0] : (bus.i_funct3[1:0] != 2'b11);
    assign b_sgn    = bus.i_funct3[2] ? ~bus.i_funct3[0] : ~bus.i_funct3[1];
    assign a_neg    = a_sgn & bus.i_rs1_data[XLEN-1];
    assign b_neg    = b_sgn & bus.i_rs2_data[XLEN-1];
    assign mag_a    = a_neg ? -bus.i_rs1_data : bus.i_rs1_data;
    assign mag_b    = b_neg ? -bus.i_rs2_data : bus.i_rs2_data;
    assign div_zero = (bus.i_rs2_data == '0);
    assign div_ovf  = ~bus.i_funct3[0] & (bus.i_rs1_data == {1'b1, {(XLEN-1){1'b0}}})
                      & (bus.i_rs2_data == '1);
    // Overflow only reaches here with rs1 = most-negative, so rs1 doubles as that quotient.
    assign fast_res = div_zero ? (bus.i_funct3[1] ? bus.i_rs1_data : '1)
                               : (bus.i_funct3[1] ? '0 : bus.i_rs1_data);

    // One iteration of each datapath.
    logic [XLEN:0]     mul_sum, div_trial;
    logic [2*XLEN-1:0] mul_step, div_step, mul_fin;
    logic [XLEN-1:0]   mul_res, div_val, div_res, fin_res;

    assign mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, a_q} : '0);
    assign mul_step  = {mul_sum, prod_q[XLEN-1:1]};
    assign div_trial = prod_q[2*XLEN-1:XLEN-1] - {1'b0, b_q};
    assign div_step  = div_trial[XLEN] ? {prod_q[2*XLEN-2:0], 1'b0}
                                       : {div_trial[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
    assign mul_fin   = neg_q ? -mul_step : mul_step;
    assign mul_res   = (funct3_q[1:0] == 2'b00) ? mul_fin[XLEN-1:0] : mul_fin[2*XLEN-1:XLEN];
    assign div_val   = funct3_q[1] ? div_step[2*XLEN-1:XLEN] : div_step[XLEN-1:0];
    assign div_res   = neg_q ? -div_val : div_val;
    assign fin_res   = funct3_q[2] ? div_res : mul_res;

    // Next-state: issue in IDLE, iterate in MUL/DIV, single DONE cycle; flush wins everywhere.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        funct3_d = funct3_q;
        rd_d     = rd_q;
        neg_d    = neg_q;
        a_d      = a_q;
        b_d      = b_q;
        prod_d   = prod_q;
        res_d    = res_q;
        rd_out_d = rd_out_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.i_start && !bus.i_flush) begin
                    funct3_d = bus.i_funct3;
                    rd_d     = bus.i_rd_addr;
                    a_d      = mag_a;
                    b_d      = mag_b;
                    cnt_d    = '0;
                    prod_d   = {{XLEN{1'b0}}, bus.i_funct3[2] ? mag_a : mag_b};
                    // Remainder takes the dividend's sign; everything else the XOR.
                    neg_d    = (bus.i_funct3[2] && bus.i_funct3[1]) ? a_neg : (a_neg ^ b_neg);
                    if (bus.i_funct3[2] && (div_zero || div_ovf)) begin
                        res_d    = fast_res;
                        rd_out_d = bus.i_rd_addr;
                        state_d  = S_DONE;
                    end else begin
                        state_d  = bus.i_funct3[2] ? S_DIV : S_MUL;
                    end
                end
            end
            S_MUL, S_DIV: begin
                prod_d = (state_q == S_MUL) ? mul_step : div_step;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    res_d    = fin_res;
                    rd_out_d = rd_q;
                    state_d  = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (bus.i_flush) begin
            state_d  = S_IDLE;
            res_d    = res_q;
            rd_out_d = rd_out_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            funct3_q <= '0;
            rd_q     <= '0;
            neg_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            prod_q   <= '0;
            res_q    <= '0;
            rd_out_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            funct3_q <= funct3_d;
            rd_q     <= rd_d;
            neg_q    <= neg_d;
            a_q      <= a_d;
            b_q      <= b_d;
            prod_q   <= prod_d;
            res_q    <= res_d;
            rd_out_q <= rd_out_d;
        end
    end

    // Busy is gated by reset so the stall drops the moment reset asserts.
    assign bus.o_busy    = i_reset && ((state_q == S_IDLE && bus.i_start && !bus.i_flush)
                                       || state_q == S_MUL || state_q == S_DIV);
    assign bus.o_done    = (state_q == S_DONE) && !bus.i_flush;
    assign bus.o_result  = res_q;
    assign bus.o_rd_addr = rd_out_q;
endmodule
